// File: rtl/wwfa_input_requester_if.sv
// rtl/wwfa_input_requester_if.sv - signal bundle between a WWFA input requester and its surroundings
// Purpose: groups descriptor push, arbiter request/answer, payload and crossbar signals.
// Signals: work; desc_valid/desc_ready/desc_addr/desc_len; answer0..answer3 (3b: [2]=no grant,
//   [1:0]=winning input); req/addr; pay_valid/pay_ready/pay_data; xb_data/xb_valid; busy; fifo_count.
// Modports: master = the requester, slave = the environment driving it.
interface wwfa_input_requester_if #(
  parameter int DATA_W     = 4,
  parameter int LEN_W      = 4,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              work;
  logic              desc_valid;
  logic              desc_ready;
  logic [1:0]        desc_addr;
  logic [LEN_W-1:0]  desc_len;
  logic [2:0]        answer0;
  logic [2:0]        answer1;
  logic [2:0]        answer2;
  logic [2:0]        answer3;
  logic              req;
  logic [1:0]        addr;
  logic              pay_valid;
  logic              pay_ready;
  logic [DATA_W-1:0] pay_data;
  logic [DATA_W-1:0] xb_data;
  logic              xb_valid;
  logic              busy;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    input  work, desc_valid, desc_addr, desc_len,
    input  answer0, answer1, answer2, answer3,
    input  pay_valid, pay_data,
    output desc_ready, req, addr, pay_ready, xb_data, xb_valid, busy, fifo_count
  );

  modport slave (
    output work, desc_valid, desc_addr, desc_len,
    output answer0, answer1, answer2, answer3,
    output pay_valid, pay_data,
    input  desc_ready, req, addr, pay_ready, xb_data, xb_valid, busy, fifo_count
  );
endinterface

// File: rtl/wwfa_input_requester.sv
// rtl/wwfa_input_requester.sv - input-port requester for the 4x4 wavefront crossbar arbiter
// Purpose: queues packet descriptors, requests the destination output, waits for its own grant
//   on that output's answer bus, streams len+1 payload words onto the crossbar, then releases.
// Ports: clk - rising-edge clock; reset - asynchronous active-high clear;
//   bus (master modport) - descriptor push, request/answer, payload in, crossbar out, status.
module wwfa_input_requester #(
  parameter int PORT_ID    = 0,
  parameter int DATA_W     = 4,
  parameter int LEN_W      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  wwfa_input_requester_if.master bus
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  // The wait counter only ever holds 0..TIMEOUT-1 before it is cleared.
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_BACKOFF,
    S_SEND,
    S_RELEASE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        fifo_addr_q [FIFO_DEPTH];
  logic [1:0]        fifo_addr_d [FIFO_DEPTH];
  logic [LEN_W-1:0]  fifo_len_q  [FIFO_DEPTH];
  logic [LEN_W-1:0]  fifo_len_d  [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [1:0]        addr_q, addr_d;
  logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic             full, empty, push, pop, desc_ready, grant, xb_valid;
  logic [2:0]       sel_answer;
  logic [1:0]       head_addr;
  logic [LEN_W-1:0] head_len;

  assign full       = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty      = (count_q == '0);
  assign pop        = (state_q == S_RELEASE);
  // The slot freed by the pop is immediately reusable, so a push in the
  // release cycle is accepted even when the FIFO is full.
  assign desc_ready = !full || pop;
  assign push       = bus.desc_valid && desc_ready;
  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_len   = fifo_len_q[rd_ptr_q];

  always_comb begin
    sel_answer = bus.answer0;
    case (addr_q)
      2'd1:    sel_answer = bus.answer1;
      2'd2:    sel_answer = bus.answer2;
      2'd3:    sel_answer = bus.answer3;
      default: sel_answer = bus.answer0;
    endcase
  end

  assign grant = bus.work && !sel_answer[2] && (sel_answer[1:0] == 2'(PORT_ID));

  // Descriptor FIFO; the head stays in place until its packet completes.
  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_len_d  = fifo_len_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push) begin
      fifo_addr_d[wr_ptr_q] = bus.desc_addr;
      fifo_len_d[wr_ptr_q]  = bus.desc_len;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    word_cnt_d = word_cnt_q;
    wait_d     = wait_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_REQ;
          addr_d  = head_addr;
          wait_d  = '0;
        end
      end
      S_REQ: begin
        if (grant) begin
          state_d    = S_SEND;
          word_cnt_d = head_len;
          wait_d     = '0;
        end else if ((TIMEOUT != 0) && (int'(wait_q) == TIMEOUT - 1)) begin
          state_d = S_BACKOFF;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_BACKOFF: begin
        state_d = S_REQ;
        wait_d  = '0;
      end
      S_SEND: begin
        if (bus.pay_valid) begin
          if (word_cnt_q == '0) begin
            state_d = S_RELEASE;
          end else begin
            word_cnt_d = word_cnt_q - LEN_W'(1);
          end
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      word_cnt_q <= '0;
      wait_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_len_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      word_cnt_q  <= word_cnt_d;
      wait_q      <= wait_d;
      fifo_addr_q <= fifo_addr_d;
      fifo_len_q  <= fifo_len_d;
    end
  end

  // Payload passes straight through in SEND so a word reaches the crossbar in the cycle it is offered.
  assign xb_valid       = (state_q == S_SEND) && bus.pay_valid;
  assign bus.xb_valid   = xb_valid;
  assign bus.xb_data    = xb_valid ? bus.pay_data : {DATA_W{1'b0}};
  assign bus.pay_ready  = (state_q == S_SEND);
  assign bus.req        = (state_q == S_REQ) || (state_q == S_SEND);
  assign bus.addr       = addr_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.desc_ready = desc_ready;
  assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_wwfa_input_requester.sv
// tb/tb_wwfa_input_requester.sv - self-checking bench for wwfa_input_requester
module tb_wwfa_input_requester;
  localparam int PORT_ID = 1;
  localparam logic [2:0] GNT  = 3'b001;
  localparam logic [2:0] NONE = 3'b100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] m_addr[$];
  logic [3:0] m_len[$];

  wwfa_input_requester_if #(.DATA_W(4), .LEN_W(4), .FIFO_DEPTH(4)) bus ();

  wwfa_input_requester #(
    .PORT_ID(PORT_ID), .DATA_W(4), .LEN_W(4), .FIFO_DEPTH(4), .TIMEOUT(15)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_answer(input int idx, input logic [2:0] v);
    case (idx)
      0: bus.answer0 = v;
      1: bus.answer1 = v;
      2: bus.answer2 = v;
      default: bus.answer3 = v;
    endcase
  endtask

  task automatic quiet_answers();
    for (int b = 0; b < 4; b++) set_answer(b, NONE);
  endtask

  task automatic push_desc(input logic [1:0] a, input logic [3:0] l);
    bus.desc_valid = 1'b1;
    bus.desc_addr  = a;
    bus.desc_len   = l;
    cyc();
    bus.desc_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.work = 1'b1; bus.desc_valid = 1'b0; bus.desc_addr = '0; bus.desc_len = '0;
    bus.pay_valid = 1'b0; bus.pay_data = '0;
    quiet_answers();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    settle();
    n_cmp++; if (bus.req !== 1'b0) begin n_err++; $display("FAIL rst_req got %0h exp 0", bus.req); end
    n_cmp++; if (bus.addr !== 2'd0) begin n_err++; $display("FAIL rst_addr got %0h exp 0", bus.addr); end
    n_cmp++; if (bus.xb_valid !== 1'b0) begin n_err++; $display("FAIL rst_xb_valid got %0h exp 0", bus.xb_valid); end
    n_cmp++; if (bus.xb_data !== 4'd0) begin n_err++; $display("FAIL rst_xb_data got %0h exp 0", bus.xb_data); end
    n_cmp++; if (bus.pay_ready !== 1'b0) begin n_err++; $display("FAIL rst_pay_ready got %0h exp 0", bus.pay_ready); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %0h exp 0", bus.busy); end
    n_cmp++; if (bus.fifo_count !== 3'd0) begin n_err++; $display("FAIL rst_count got %0d exp 0", bus.fifo_count); end
    n_cmp++; if (bus.desc_ready !== 1'b1) begin n_err++; $display("FAIL rst_desc_ready got %0h exp 1", bus.desc_ready); end
  endtask

  task automatic test_basic_packet();
    logic [3:0] w[4];
    for (int i = 0; i < 4; i++) w[i] = 4'($urandom_range(0, 15));
    push_desc(2'd2, 4'd3);
    settle();
    n_cmp++; if (bus.req !== 1'b0) begin n_err++; $display("FAIL basic_req_idle got %0h exp 0", bus.req); end
    n_cmp++; if (bus.fifo_count !== 3'd1) begin n_err++; $display("FAIL basic_count1 got %0d exp 1", bus.fifo_count); end
    cyc();
    n_cmp++; if (bus.req !== 1'b1) begin n_err++; $display("FAIL basic_req_up got %0h exp 1", bus.req); end
    n_cmp++; if (bus.addr !== 2'd2) begin n_err++; $display("FAIL basic_addr got %0h exp 2", bus.addr); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++; if (bus.req !== 1'b1 || bus.pay_ready !== 1'b0) begin n_err++; $display("FAIL basic_nogrant req %0h pay_ready %0h exp 1/0", bus.req, bus.pay_ready); end
    end
    bus.answer2 = GNT;
    bus.pay_valid = 1'b1;
    bus.pay_data = w[0];
    cyc();
    bus.answer2 = NONE;
    for (int i = 0; i < 4; i++) begin
      bus.pay_data = w[i];
      settle();
      n_cmp++; if (bus.xb_valid !== 1'b1 || bus.xb_data !== w[i]) begin n_err++; $display("FAIL basic_word%0d got v%0h d%0h exp v1 d%0h", i, bus.xb_valid, bus.xb_data, w[i]); end
      cyc();
    end
    settle();
    n_cmp++; if (bus.xb_valid !== 1'b0 || bus.req !== 1'b0 || bus.busy !== 1'b1) begin n_err++; $display("FAIL basic_release xbv %0h req %0h busy %0h exp 0/0/1", bus.xb_valid, bus.req, bus.busy); end
    bus.pay_valid = 1'b0;
    cyc();
    n_cmp++; if (bus.fifo_count !== 3'd0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL basic_done count %0d busy %0h exp 0/0", bus.fifo_count, bus.busy); end
  endtask

  task automatic test_timeout();
    int hi, lim;
    push_desc(2'd0, 4'd0);
    bus.answer0 = 3'b000;
    bus.answer1 = GNT;
    cyc();
    hi = 0; lim = 0;
    if (bus.req === 1'b1) hi = 1;
    while (lim < 40 && hi > 0) begin
      cyc(); lim++;
      if (bus.req === 1'b1) hi++;
      else break;
    end
    n_cmp++; if (hi != 15) begin n_err++; $display("FAIL timeout_req_high_cycles got %0d exp 15", hi); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL timeout_backoff_busy got %0h exp 1", bus.busy); end
    cyc();
    n_cmp++; if (bus.req !== 1'b1) begin n_err++; $display("FAIL timeout_reassert got %0h exp 1", bus.req); end
    bus.answer1 = NONE;
    bus.answer0 = GNT;
    bus.pay_valid = 1'b1;
    bus.pay_data = 4'h9;
    cyc();
    settle();
    n_cmp++; if (bus.xb_valid !== 1'b1 || bus.xb_data !== 4'h9) begin n_err++; $display("FAIL timeout_send got v%0h d%0h exp v1 d9", bus.xb_valid, bus.xb_data); end
    quiet_answers();
    cyc();
    bus.pay_valid = 1'b0;
    cyc();
    n_cmp++; if (bus.busy !== 1'b0 || bus.fifo_count !== 3'd0) begin n_err++; $display("FAIL timeout_done busy %0h count %0d exp 0/0", bus.busy, bus.fifo_count); end
  endtask

  task automatic test_work_gate();
    push_desc(2'd3, 4'd0);
    cyc();
    bus.work = 1'b0;
    bus.answer3 = GNT;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++; if (bus.pay_ready !== 1'b0 || bus.req !== 1'b1) begin n_err++; $display("FAIL work0_ignored pay_ready %0h req %0h exp 0/1", bus.pay_ready, bus.req); end
    end
    bus.work = 1'b1;
    bus.pay_valid = 1'b1;
    bus.pay_data = 4'h5;
    cyc();
    settle();
    n_cmp++; if (bus.pay_ready !== 1'b1 || bus.xb_data !== 4'h5) begin n_err++; $display("FAIL work1_send pay_ready %0h xb_data %0h exp 1/5", bus.pay_ready, bus.xb_data); end
    quiet_answers();
    cyc();
    bus.pay_valid = 1'b0;
    cyc();
  endtask

  task automatic test_send_gaps();
    bit pv[4];
    logic [3:0] pd;
    pv = '{1'b1, 1'b0, 1'b0, 1'b1};
    push_desc(2'd1, 4'd1);
    cyc();
    bus.answer1 = GNT;
    cyc();
    bus.answer1 = NONE;
    for (int i = 0; i < 4; i++) begin
      pd = 4'($urandom_range(0, 15));
      bus.pay_valid = pv[i];
      bus.pay_data = pd;
      settle();
      n_cmp++; if (bus.xb_valid !== pv[i] || bus.xb_data !== (pv[i] ? pd : 4'd0) || bus.req !== 1'b1) begin n_err++; $display("FAIL gaps_cycle%0d got v%0h d%0h req %0h exp v%0h", i, bus.xb_valid, bus.xb_data, bus.req, pv[i]); end
      cyc();
    end
    bus.pay_valid = 1'b1;
    settle();
    n_cmp++; if (bus.req !== 1'b0 || bus.pay_ready !== 1'b0 || bus.xb_valid !== 1'b0 || bus.busy !== 1'b1) begin n_err++; $display("FAIL gaps_release req %0h pr %0h xbv %0h busy %0h exp 0/0/0/1", bus.req, bus.pay_ready, bus.xb_valid, bus.busy); end
    bus.pay_valid = 1'b0;
    cyc();
  endtask

  task automatic test_fifo_full();
    logic [1:0] a, ha, na;
    logic [3:0] l, hl, nl;
    int lim;
    bus.work = 1'b0;
    quiet_answers();
    for (int i = 0; i < 4; i++) begin
      a = 2'($urandom_range(0, 3)); l = 4'($urandom_range(0, 3));
      push_desc(a, l);
      m_addr.push_back(a); m_len.push_back(l);
    end
    settle();
    n_cmp++; if (bus.fifo_count !== 3'd4 || bus.desc_ready !== 1'b0) begin n_err++; $display("FAIL full_state count %0d ready %0h exp 4/0", bus.fifo_count, bus.desc_ready); end
    ha = m_addr[0]; hl = m_len[0];
    push_desc(~ha, ~hl);
    settle();
    n_cmp++; if (bus.fifo_count !== 3'd4) begin n_err++; $display("FAIL full_drop count %0d exp 4", bus.fifo_count); end
    bus.work = 1'b1;
    set_answer(ha, GNT);
    bus.pay_valid = 1'b1;
    lim = 0;
    cyc();
    while (bus.pay_ready !== 1'b1 && lim < 3) begin cyc(); lim++; end
    n_cmp++; if (bus.pay_ready !== 1'b1) begin n_err++; $display("FAIL full_grant pay_ready %0h exp 1", bus.pay_ready); end
    set_answer(ha, NONE);
    na = 2'($urandom_range(0, 3)); nl = 4'($urandom_range(0, 15));
    for (int i = 0; i <= int'(hl); i++) begin
      bus.pay_data = 4'($urandom_range(0, 15));
      if (i == int'(hl)) begin
        bus.desc_valid = 1'b1; bus.desc_addr = na; bus.desc_len = nl;
      end
      settle();
      n_cmp++; if (bus.xb_valid !== 1'b1) begin n_err++; $display("FAIL full_word%0d xb_valid %0h exp 1", i, bus.xb_valid); end
      cyc();
    end
    settle();
    n_cmp++; if (bus.desc_ready !== 1'b1 || bus.req !== 1'b0) begin n_err++; $display("FAIL full_release ready %0h req %0h exp 1/0", bus.desc_ready, bus.req); end
    cyc();
    bus.desc_valid = 1'b0;
    bus.pay_valid = 1'b0;
    settle();
    n_cmp++; if (bus.fifo_count !== 3'd4) begin n_err++; $display("FAIL full_push_on_pop count %0d exp 4", bus.fifo_count); end
    void'(m_addr.pop_front()); void'(m_len.pop_front());
    m_addr.push_back(na); m_len.push_back(nl);
  endtask

  task automatic test_random();
    logic [1:0] a, ha;
    logic [3:0] l, hl, pd;
    logic [2:0] v;
    logic pv;
    int np, lim, d, sent;
    quiet_answers();
    bus.work = 1'b1;
    for (int r = 0; r < 60 && (r < 16 || m_addr.size() != 0); r++) begin
      if (r < 16) begin
        np = $urandom_range(0, 2);
        for (int k = 0; k < np; k++) begin
          if (m_addr.size() < 4) begin
            a = 2'($urandom_range(0, 3)); l = 4'($urandom_range(0, 15));
            push_desc(a, l);
            m_addr.push_back(a); m_len.push_back(l);
          end
        end
      end
      if (m_addr.size() == 0) continue;
      settle();
      n_cmp++; if (bus.fifo_count !== 3'(m_addr.size())) begin n_err++; $display("FAIL rnd%0d_count got %0d exp %0d", r, bus.fifo_count, m_addr.size()); end
      ha = m_addr[0]; hl = m_len[0];
      lim = 0;
      while (bus.req !== 1'b1 && lim < 20) begin cyc(); lim++; end
      n_cmp++; if (bus.req !== 1'b1 || bus.addr !== ha) begin n_err++; $display("FAIL rnd%0d_req req %0h addr %0h exp 1/%0h", r, bus.req, bus.addr, ha); end
      d = $urandom_range(0, 20);
      for (int k = 0; k < d; k++) begin
        bus.work = 1'($urandom_range(0, 1));
        for (int b = 0; b < 4; b++) begin
          v = 3'($urandom_range(0, 7));
          if (b == int'(ha) && v == GNT) v = 3'b101;
          set_answer(b, v);
        end
        cyc();
        n_cmp++; if (bus.pay_ready !== 1'b0) begin n_err++; $display("FAIL rnd%0d_spurious_grant pay_ready %0h exp 0", r, bus.pay_ready); end
      end
      bus.work = 1'b1;
      quiet_answers();
      set_answer(ha, GNT);
      lim = 0;
      cyc();
      while (bus.pay_ready !== 1'b1 && lim < 3) begin cyc(); lim++; end
      n_cmp++; if (bus.pay_ready !== 1'b1) begin n_err++; $display("FAIL rnd%0d_grant pay_ready %0h exp 1", r, bus.pay_ready); end
      sent = 0; lim = 0;
      while (sent <= int'(hl) && lim < 200) begin
        pv = ($urandom_range(0, 3) != 0);
        pd = 4'($urandom_range(0, 15));
        bus.pay_valid = pv; bus.pay_data = pd;
        for (int b = 0; b < 4; b++) set_answer(b, 3'($urandom_range(0, 7)));
        settle();
        n_cmp++; if (bus.pay_ready !== 1'b1 || bus.xb_valid !== pv || bus.xb_data !== (pv ? pd : 4'd0)) begin n_err++; $display("FAIL rnd%0d_word%0d pr %0h v%0h d%0h exp pr1 v%0h d%0h", r, sent, bus.pay_ready, bus.xb_valid, bus.xb_data, pv, pv ? pd : 4'd0); end
        if (pv) sent++;
        cyc(); lim++;
      end
      bus.pay_valid = 1'b1;
      quiet_answers();
      settle();
      n_cmp++; if (bus.req !== 1'b0 || bus.pay_ready !== 1'b0 || bus.busy !== 1'b1) begin n_err++; $display("FAIL rnd%0d_release req %0h pr %0h busy %0h exp 0/0/1", r, bus.req, bus.pay_ready, bus.busy); end
      bus.pay_valid = 1'b0;
      void'(m_addr.pop_front()); void'(m_len.pop_front());
      cyc();
    end
    settle();
    n_cmp++; if (bus.fifo_count !== 3'd0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL rnd_drained count %0d busy %0h exp 0/0", bus.fifo_count, bus.busy); end
  endtask

  task automatic test_reset_mid_send();
    quiet_answers();
    bus.work = 1'b1;
    push_desc(2'd2, 4'd15);
    push_desc(2'd0, 4'd3);
    bus.answer2 = GNT;
    bus.pay_valid = 1'b1;
    bus.pay_data = 4'hA;
    cyc(); cyc();
    settle();
    n_cmp++; if (bus.xb_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre xb_valid %0h exp 1", bus.xb_valid); end
    reset = 1'b1;
    settle();
    n_cmp++; if (bus.req !== 1'b0 || bus.xb_valid !== 1'b0 || bus.busy !== 1'b0 || bus.pay_ready !== 1'b0) begin n_err++; $display("FAIL midrst_outputs req %0h xbv %0h busy %0h pr %0h exp 0", bus.req, bus.xb_valid, bus.busy, bus.pay_ready); end
    n_cmp++; if (bus.fifo_count !== 3'd0 || bus.desc_ready !== 1'b1) begin n_err++; $display("FAIL midrst_fifo count %0d ready %0h exp 0/1", bus.fifo_count, bus.desc_ready); end
    bus.pay_valid = 1'b0;
    quiet_answers();
    cyc();
    reset = 1'b0;
    cyc(); cyc();
    n_cmp++; if (bus.busy !== 1'b0 || bus.req !== 1'b0 || bus.desc_ready !== 1'b1) begin n_err++; $display("FAIL midrst_after busy %0h req %0h ready %0h exp 0/0/1", bus.busy, bus.req, bus.desc_ready); end
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_timeout();
    test_work_gate();
    test_send_gaps();
    test_fifo_full();
    test_random();
    test_reset_mid_send();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
